// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } dmem_state_e;

  localparam int unsigned DMEM_CNT_W      = 4;
  localparam int unsigned DMEM_WORD_BYTES = 4;

  // A byte address is word aligned when its in-word offset bits are zero.
  function automatic logic dmem_is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port synchronous data SRAM: write-enable, word index, registered read data.
module dmem_sram_array import dmem_pkg::*; #(
  parameter int unsigned AddrW = 10,
  parameter int unsigned DataW = DMEM_WORD_BYTES * 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] idx_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_o <= mem_q[idx_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one load/store, stalls through the wait states, commits.
// Optional misaligned-access suppression is built when DMEM_ALIGN_CHECK_EN is defined.
module dmem_responder import dmem_pkg::*; #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        RespValidM,
  output logic        StallM,
  output logic        MisalignM
);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit AlignCheck = 1'b1;
`else
  localparam bit AlignCheck = 1'b0;
`endif

  localparam logic [DMEM_CNT_W-1:0] CntLoad = DMEM_CNT_W'(WAIT_STATES);

  dmem_state_e           state_q;
  logic [DMEM_CNT_W-1:0] cnt_q;
  logic [ADDR_W-1:0]     idx_q;
  logic [31:0]           wdata_q;
  logic                  store_q;
  logic                  misal_q;
  logic                  misal_resp_q;

  logic              req;
  logic              req_misal;
  logic              commit;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_idx;
  logic [31:0]       sram_rdata;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^ALUOutM[31:ADDR_W+2];

  assign req       = MemReadM | MemWriteM;
  assign req_misal = AlignCheck & dmem_is_misaligned(ALUOutM[1:0]);
  assign commit    = (state_q == StWait) && (cnt_q == '0);

  // Reset in the commit cycle must win over the store.
  assign sram_we  = rst & commit & store_q & ~misal_q;
  // The read port follows the live address in IDLE so the word is ready by the commit edge
  // even with zero wait states.
  assign sram_idx = (state_q == StIdle) ? ALUOutM[ADDR_W+1:2] : idx_q;

  assign StallM    = rst & (((state_q == StIdle) & req) | (state_q == StWait));
  assign MisalignM = AlignCheck ? misal_resp_q : 1'b0;

  dmem_sram_array #(
    .AddrW(ADDR_W),
    .DataW(32)
  ) u_sram (
    .clk_i  (CLK),
    .we_i   (sram_we),
    .idx_i  (sram_idx),
    .wdata_i(wdata_q),
    .rdata_o(sram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ReadDataM    <= '0;
      RespValidM   <= 1'b0;
      misal_resp_q <= 1'b0;
    end else begin
      RespValidM   <= 1'b0;
      misal_resp_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            idx_q   <= ALUOutM[ADDR_W+1:2];
            wdata_q <= WriteDataM;
            store_q <= MemWriteM;
            misal_q <= req_misal;
            cnt_q   <= CntLoad;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - DMEM_CNT_W'(1);
          end else begin
            state_q      <= StDone;
            RespValidM   <= 1'b1;
            misal_resp_q <= misal_q;
            if (misal_q) begin
              ReadDataM <= '0;
            end else if (!store_q) begin
              ReadDataM <= sram_rdata;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (one and zero wait states) against a word-array model.
module tb_dmem_responder;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        rd     [2];
  logic        wr     [2];
  logic [31:0] addr   [2];
  logic [31:0] wd     [2];
  logic [31:0] rdata  [2];
  logic        rvalid [2];
  logic        stall  [2];
  logic        misal  [2];

  int          checks = 0;
  int          errors = 0;
  int          ws     [2] = '{1, 0};
  logic [31:0] mdl    [2][DEPTH];
  bit          known  [2][DEPTH];
  logic [31:0] rd_exp [2];

  always #5 CLK = ~CLK;

  dmem_responder #(.ADDR_W(AW), .WAIT_STATES(1)) u_ws1 (
    .CLK       (CLK),
    .rst       (rst),
    .MemReadM  (rd[0]),
    .MemWriteM (wr[0]),
    .ALUOutM   (addr[0]),
    .WriteDataM(wd[0]),
    .ReadDataM (rdata[0]),
    .RespValidM(rvalid[0]),
    .StallM    (stall[0]),
    .MisalignM (misal[0])
  );

  dmem_responder #(.ADDR_W(AW), .WAIT_STATES(0)) u_ws0 (
    .CLK       (CLK),
    .rst       (rst),
    .MemReadM  (rd[1]),
    .MemWriteM (wr[1]),
    .ALUOutM   (addr[1]),
    .WriteDataM(wd[1]),
    .ReadDataM (rdata[1]),
    .RespValidM(rvalid[1]),
    .StallM    (stall[1]),
    .MisalignM (misal[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wd[u] = '0;
    end
  endtask

  // Called #1 after a rising edge with the unit in IDLE; returns likewise.
  task automatic access(input int u, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int unsigned idx = (a / 4) % DEPTH;
    bit          mis = AlignEn && (a % 4 != 0);
    rd[u] = r; wr[u] = w; addr[u] = a; wd[u] = d;
    @(negedge CLK);
    check({tag, ":stall_accept"}, {31'b0, stall[u]}, 1);
    check({tag, ":rvalid_accept"}, {31'b0, rvalid[u]}, 0);
    for (int i = 0; i <= ws[u]; i++) begin
      @(posedge CLK); #1;
      rd[u] = 1'($urandom_range(1)); wr[u] = 1'($urandom_range(1));
      addr[u] = $urandom; wd[u] = $urandom;
      @(negedge CLK);
      check({tag, ":stall_wait"}, {31'b0, stall[u]}, 1);
      check({tag, ":rvalid_wait"}, {31'b0, rvalid[u]}, 0);
    end
    @(posedge CLK); #1;
    rd[u] = 1'b0; wr[u] = 1'b0;
    if (mis) rd_exp[u] = 32'h0;
    else if (w) begin
      mdl[u][idx] = d; known[u][idx] = 1'b1;
    end else rd_exp[u] = mdl[u][idx];
    @(negedge CLK);
    check({tag, ":stall_done"}, {31'b0, stall[u]}, 0);
    check({tag, ":rvalid_done"}, {31'b0, rvalid[u]}, 1);
    check({tag, ":misal_done"}, {31'b0, misal[u]}, {31'b0, mis});
    check({tag, ":rdata_done"}, rdata[u], rd_exp[u]);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input int cycles, input bit hold_write);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = hold_write; addr[u] = 32'h20; wd[u] = 32'hBAD0BAD0;
    end
    repeat (cycles) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      for (int u = 0; u < 2; u++) begin
        check("rst:stall", {31'b0, stall[u]}, 0);
        check("rst:rvalid", {31'b0, rvalid[u]}, 0);
        check("rst:misal", {31'b0, misal[u]}, 0);
        check("rst:rdata", rdata[u], 0);
      end
    end
    rst = 1'b1;
    idle_inputs();
    rd_exp[0] = 32'h0; rd_exp[1] = 32'h0;
    @(posedge CLK); #1;
  endtask

  // Start a store, then pull reset low after k cycles of WAIT; the store must be dropped.
  task automatic abort_store(input int u, input logic [31:0] a, input logic [31:0] d, input int k);
    rd[u] = 1'b0; wr[u] = 1'b1; addr[u] = a; wd[u] = d;
    @(negedge CLK);
    check("abort:stall_accept", {31'b0, stall[u]}, 1);
    @(posedge CLK); #1;
    repeat (k) begin
      @(posedge CLK); #1;
    end
    rst = 1'b0;
    @(negedge CLK);
    check("abort:stall_in_rst", {31'b0, stall[u]}, 0);
    @(posedge CLK); #1;
    rst = 1'b1;
    idle_inputs();
    rd_exp[0] = 32'h0; rd_exp[1] = 32'h0;
    @(negedge CLK);
    check("abort:stall_after", {31'b0, stall[u]}, 0);
    check("abort:rvalid_after", {31'b0, rvalid[u]}, 0);
    check("abort:rdata_after", rdata[u], 0);
    @(posedge CLK); #1;
  endtask

  initial begin
    idle_inputs();
    rd_exp[0] = 32'h0; rd_exp[1] = 32'h0;
    do_reset(2, 1'b0);

    // Reset with a store held on the inputs must not write.
    access(0, 0, 1, 32'h20, 32'h11111111, "preload0");
    access(1, 0, 1, 32'h20, 32'h22222222, "preload1");
    do_reset(2, 1'b1);
    access(0, 1, 0, 32'h20, 32'h0, "rst_noload0");
    access(1, 1, 0, 32'h20, 32'h0, "rst_noload1");

    access(0, 0, 1, 32'h40, 32'hDEADBEEF, "st40");
    access(0, 1, 0, 32'h40, 32'h0, "ld40");

    access(1, 0, 1, 32'h0, 32'hCAFE0000, "st0");
    access(1, 0, 1, 32'h4, 32'hCAFE0004, "st4");
    access(1, 1, 0, 32'h0, 32'h0, "b2b_ld0");
    access(1, 1, 0, 32'h4, 32'h0, "b2b_ld4");

    // Both strobes high behaves as a store; ReadDataM keeps DEADBEEF.
    access(0, 1, 1, 32'h8, 32'h5, "both8");
    access(0, 1, 0, 32'h8, 32'h0, "ld8");

    access(0, 0, 1, 32'h10, 32'hA5A5A5A5, "pre10");
    access(1, 0, 1, 32'h14, 32'h5A5A5A5A, "pre14");
    access(0, 0, 1, 32'h18, 32'h0F0F0F0F, "pre18");
    abort_store(0, 32'h10, 32'h12345678, 0);
    abort_store(1, 32'h14, 32'h87654321, 0);
    abort_store(0, 32'h18, 32'hFFFFFFFF, 1);
    access(0, 1, 0, 32'h10, 32'h0, "ld10");
    access(1, 1, 0, 32'h14, 32'h0, "ld14");
    access(0, 1, 0, 32'h18, 32'h0, "ld18");

    access(0, 0, 1, 32'h42, 32'h12345678, "st42");
    access(0, 1, 0, 32'h40, 32'h0, "ld40b");
    access(0, 1, 0, 32'h43, 32'h0, "ld43");

    // Aliasing: upper address bits beyond the array are ignored.
    access(1, 0, 1, 32'h0000_1004, 32'h0A11A5ED, "alias_st");
    access(1, 1, 0, 32'h0000_0004, 32'h0, "alias_ld");

    repeat (80) begin
      int unsigned u   = $urandom_range(1);
      int unsigned idx = $urandom_range(15);
      int unsigned lo  = ($urandom_range(3) == 0) ? $urandom_range(3) : 0;
      int unsigned t   = $urandom_range(2);
      logic [31:0] a   = ($urandom << (AW + 2)) | (idx << 2) | lo;
      bit          r   = (t != 1);
      bit          w   = (t != 0);
      if (!w && !known[u][idx] && !(AlignEn && lo != 0)) begin
        r = 1'b0; w = 1'b1;
      end
      access(int'(u), r, w, a, $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
